// File: rtl/rw_stage.sv
`default_nettype none
// ============================================================================
// Module      : rw_stage
// Description : RISC-32 register-writeback stage. It holds the MA/RW pipeline
//               latch, selects the writeback value, owns the 16 x 32 register
//               file with two combinational read ports, and counts retired
//               instructions.
//               Optional feature: define RW_BYPASS_EN to forward the in-flight
//               writeback onto the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module rw_stage #(
    parameter int unsigned RESET_PC_INC = 4,
    parameter int unsigned NREGS        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_ld_result,
    input  logic [3:0]  in_rd,
    input  logic        in_is_ld,
    input  logic        in_is_call,
    input  logic        in_is_wb,
    input  logic [3:0]  rd_addr1,
    input  logic [3:0]  rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] retired_count
);

    localparam logic [3:0]  c_RA_ADDR = 4'(NREGS - 1);
    localparam logic [31:0] c_PC_INC  = 32'(RESET_PC_INC);

    // Pipeline latch
    logic        r_valid;
    logic        r_committed;
    logic [31:0] r_pc;
    logic [31:0] r_aluResult;
    logic [31:0] r_ldResult;
    logic [3:0]  r_rd;
    logic        r_isLd;
    logic        r_isCall;
    logic        r_isWb;

    logic [31:0] r_regs [NREGS];
    logic [31:0] r_retiredCount;

    logic        w_wbValid;
    logic [3:0]  w_wbRd;
    logic [31:0] w_wbData;
    logic        w_capture;
    logic        w_firstCycle;

    assign w_capture    = !flush && !stall;
    // An instruction retires once, in the first cycle it sits in the latch.
    assign w_firstCycle = r_valid && !r_committed;

    always_comb begin
        w_wbData = r_aluResult;
        if (r_isCall) begin
            w_wbData = r_pc + c_PC_INC;
        end else if (r_isLd) begin
            w_wbData = r_ldResult;
        end
    end

    assign w_wbRd    = r_isCall ? c_RA_ADDR : r_rd;
    assign w_wbValid = w_firstCycle && (r_isWb || r_isCall);

    // Control half of the latch plus architectural state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid        <= 1'b0;
            r_committed    <= 1'b0;
            r_retiredCount <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wbValid) begin
                r_regs[w_wbRd] <= w_wbData;
            end
            if (w_firstCycle) begin
                r_retiredCount <= r_retiredCount + 32'd1;
            end
            if (flush) begin
                r_valid     <= 1'b0;
                r_committed <= 1'b0;
            end else if (stall) begin
                if (r_valid) begin
                    r_committed <= 1'b1;
                end
            end else begin
                r_valid     <= in_valid;
                r_committed <= 1'b0;
            end
        end
    end

    // Data half of the latch; contents are don't-care while valid is low.
    always_ff @(posedge clk) begin
        if (!reset && w_capture) begin
            r_pc        <= in_pc;
            r_aluResult <= in_alu_result;
            r_ldResult  <= in_ld_result;
            r_rd        <= in_rd;
            r_isLd      <= in_is_ld;
            r_isCall    <= in_is_call;
            r_isWb      <= in_is_wb;
        end
    end

`ifdef RW_BYPASS_EN
    assign rd_data1 = (w_wbValid && (rd_addr1 == w_wbRd)) ? w_wbData : r_regs[rd_addr1];
    assign rd_data2 = (w_wbValid && (rd_addr2 == w_wbRd)) ? w_wbData : r_regs[rd_addr2];
`else
    assign rd_data1 = r_regs[rd_addr1];
    assign rd_data2 = r_regs[rd_addr2];
`endif

    assign wb_valid      = w_wbValid;
    assign wb_rd         = w_wbRd;
    assign wb_data       = w_wbData;
    assign retired_count = r_retiredCount;

endmodule
`default_nettype wire

// File: tb/tb_rw_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rw_stage
// Description : Self-checking bench for rw_stage: directed scenarios followed
//               by randomized traffic against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rw_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] in_pc, in_alu_result, in_ld_result;
    logic [3:0]  in_rd, rd_addr1, rd_addr2;
    logic        in_is_ld, in_is_call, in_is_wb;
    logic [31:0] rd_data1, rd_data2, wb_data, retired_count;
    logic        wb_valid;
    logic [3:0]  wb_rd;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    rw_stage #(.RESET_PC_INC(4), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_alu_result(in_alu_result),
        .in_ld_result(in_ld_result), .in_rd(in_rd), .in_is_ld(in_is_ld),
        .in_is_call(in_is_call), .in_is_wb(in_is_wb),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .retired_count(retired_count)
    );

    // Instruction-level model: the instruction in the stage, resolved at
    // acceptance to its destination and value, and whether it is still pending.
    logic [31:0] mRegs [16];
    logic [31:0] mCount;
    logic        mHas, mPending, mWrites;
    logic [3:0]  mRd;
    logic [31:0] mData;

    function automatic logic [31:0] mRead(input logic [3:0] a);
`ifdef RW_BYPASS_EN
        if (mHas && mPending && mWrites && a == mRd) return mData;
`endif
        return mRegs[a];
    endfunction

    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 16; i++) mRegs[i] = 32'd0;
            mCount = 32'd0; mHas = 1'b0; mPending = 1'b0;
        end else begin
            if (mHas && mPending) begin
                if (mWrites) mRegs[mRd] = mData;
                mCount = mCount + 32'd1;
            end
            if (flush) mHas = 1'b0;
            else if (stall) mPending = 1'b0;
            else begin
                mHas     = in_valid;
                mPending = 1'b1;
                mWrites  = in_is_wb | in_is_call;
                mRd      = in_is_call ? 4'd15 : in_rd;
                mData    = in_is_call ? in_pc + 32'd4 : (in_is_ld ? in_ld_result : in_alu_result);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_alu_result = '0; in_ld_result = '0; in_rd = '0;
        in_is_ld = 1'b0; in_is_call = 1'b0; in_is_wb = 1'b0;
    endtask

    task automatic present(input logic [3:0] rd, input logic [31:0] alu);
        in_valid = 1'b1; in_is_wb = 1'b1; in_is_ld = 1'b0; in_is_call = 1'b0;
        in_rd = rd; in_alu_result = alu; in_ld_result = 32'h0; in_pc = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; rd_addr1 = 4'd0; rd_addr2 = 4'd15;
        tick(); tick();
        reset = 1'b0;
        nChecks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else nPass++;
        nChecks++; if (retired_count !== 32'd0) $display("FAIL reset_count got %h want 0", retired_count); else nPass++;
        nChecks++; if (rd_data1 !== 32'd0) $display("FAIL reset_r0 got %h want 0", rd_data1); else nPass++;
        nChecks++; if (rd_data2 !== 32'd0) $display("FAIL reset_r15 got %h want 0", rd_data2); else nPass++;
    endtask

    task automatic test_alu_wb();
        present(4'd3, 32'h12345678); rd_addr1 = 4'd3;
        tick();
        idle();
        nChecks++; if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid got %b want 1", wb_valid); else nPass++;
        nChecks++; if (wb_rd !== 4'd3) $display("FAIL alu_wb_rd got %h want 3", wb_rd); else nPass++;
        nChecks++; if (wb_data !== 32'h12345678) $display("FAIL alu_wb_data got %h want 12345678", wb_data); else nPass++;
`ifdef RW_BYPASS_EN
        nChecks++; if (rd_data1 !== 32'h12345678) $display("FAIL alu_early_read got %h want 12345678", rd_data1); else nPass++;
`else
        nChecks++; if (rd_data1 !== 32'h0) $display("FAIL alu_early_read got %h want 0", rd_data1); else nPass++;
`endif
        tick();
        nChecks++; if (rd_data1 !== 32'h12345678) $display("FAIL alu_read got %h want 12345678", rd_data1); else nPass++;
        nChecks++; if (retired_count !== 32'd1) $display("FAIL alu_count got %h want 1", retired_count); else nPass++;
        nChecks++; if (wb_valid !== 1'b0) $display("FAIL alu_bubble got %b want 0", wb_valid); else nPass++;
    endtask

    task automatic test_call_priority();
        idle();
        in_valid = 1'b1; in_is_ld = 1'b1; in_is_call = 1'b1; in_is_wb = 1'b0;
        in_pc = 32'h100; in_ld_result = 32'hDEAD; in_alu_result = 32'hBEEF; in_rd = 4'd4;
        rd_addr2 = 4'd15;
        tick();
        idle();
        nChecks++; if (wb_valid !== 1'b1) $display("FAIL call_wb_valid got %b want 1", wb_valid); else nPass++;
        nChecks++; if (wb_rd !== 4'd15) $display("FAIL call_wb_rd got %h want f", wb_rd); else nPass++;
        nChecks++; if (wb_data !== 32'h104) $display("FAIL call_wb_data got %h want 104", wb_data); else nPass++;
        tick();
        nChecks++; if (rd_data2 !== 32'h104) $display("FAIL call_ra got %h want 104", rd_data2); else nPass++;
        nChecks++; if (retired_count !== 32'd2) $display("FAIL call_count got %h want 2", retired_count); else nPass++;
    endtask

    task automatic test_stall();
        present(4'd5, 32'h55); rd_addr1 = 4'd5;
        tick();
        // The presented instruction changes during stall and must be ignored.
        stall = 1'b1; present(4'd5, 32'h77);
        nChecks++; if (wb_valid !== 1'b1) $display("FAIL stall_first_valid got %b want 1", wb_valid); else nPass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            nChecks++; if (wb_valid !== 1'b0) $display("FAIL stall_hold_valid cycle %0d got %b want 0", c, wb_valid); else nPass++;
            nChecks++; if (retired_count !== 32'd3) $display("FAIL stall_count cycle %0d got %h want 3", c, retired_count); else nPass++;
            nChecks++; if (rd_data1 !== 32'h55) $display("FAIL stall_r5 cycle %0d got %h want 55", c, rd_data1); else nPass++;
        end
        idle();
        tick();
        tick();
        nChecks++; if (rd_data1 !== 32'h55) $display("FAIL stall_release_r5 got %h want 55", rd_data1); else nPass++;
        nChecks++; if (retired_count !== 32'd3) $display("FAIL stall_release_count got %h want 3", retired_count); else nPass++;
    endtask

    task automatic test_flush();
        present(4'd6, 32'h66); flush = 1'b1; rd_addr1 = 4'd6;
        tick();
        idle();
        nChecks++; if (wb_valid !== 1'b0) $display("FAIL flush_wb_valid got %b want 0", wb_valid); else nPass++;
        tick();
        nChecks++; if (rd_data1 !== 32'h0) $display("FAIL flush_r6 got %h want 0", rd_data1); else nPass++;
        nChecks++; if (retired_count !== 32'd3) $display("FAIL flush_count got %h want 3", retired_count); else nPass++;
        // Instruction already in the latch still commits at the flush+stall edge.
        present(4'd8, 32'h88); rd_addr2 = 4'd8;
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        idle();
        nChecks++; if (wb_valid !== 1'b0) $display("FAIL flush_stall_bubble got %b want 0", wb_valid); else nPass++;
        nChecks++; if (rd_data2 !== 32'h88) $display("FAIL flush_stall_r8 got %h want 88", rd_data2); else nPass++;
        tick();
        nChecks++; if (retired_count !== 32'd4) $display("FAIL flush_stall_count got %h want 4", retired_count); else nPass++;
    endtask

    task automatic test_bypass();
        present(4'd7, 32'hA5A5A5A5); rd_addr2 = 4'd7;
        tick();
        idle();
`ifdef RW_BYPASS_EN
        nChecks++; if (rd_data2 !== 32'hA5A5A5A5) $display("FAIL bypass_same_cycle got %h want a5a5a5a5", rd_data2); else nPass++;
`else
        nChecks++; if (rd_data2 !== 32'h0) $display("FAIL bypass_same_cycle got %h want 0", rd_data2); else nPass++;
`endif
        tick();
        nChecks++; if (rd_data2 !== 32'hA5A5A5A5) $display("FAIL bypass_later got %h want a5a5a5a5", rd_data2); else nPass++;
    endtask

    task automatic test_reset_mid_write();
        present(4'd2, 32'h22); rd_addr1 = 4'd2; rd_addr2 = 4'd7;
        tick();
        idle();
        nChecks++; if (wb_valid !== 1'b1 || wb_rd !== 4'd2) $display("FAIL rstmid_pending got %b/%h want 1/2", wb_valid, wb_rd); else nPass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nChecks++; if (rd_data1 !== 32'h0) $display("FAIL rstmid_r2 got %h want 0", rd_data1); else nPass++;
        nChecks++; if (rd_data2 !== 32'h0) $display("FAIL rstmid_r7 got %h want 0", rd_data2); else nPass++;
        nChecks++; if (retired_count !== 32'd0) $display("FAIL rstmid_count got %h want 0", retired_count); else nPass++;
        nChecks++; if (wb_valid !== 1'b0) $display("FAIL rstmid_latch got %b want 0", wb_valid); else nPass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 99) < 2);
            stall         = ($urandom_range(0, 99) < 25);
            flush         = ($urandom_range(0, 99) < 10);
            in_valid      = ($urandom_range(0, 99) < 80);
            in_is_ld      = $urandom_range(0, 1) == 1;
            in_is_call    = ($urandom_range(0, 99) < 15);
            in_is_wb      = ($urandom_range(0, 99) < 75);
            in_rd         = 4'($urandom);
            in_pc         = $urandom;
            in_alu_result = $urandom;
            in_ld_result  = $urandom;
            rd_addr1      = 4'($urandom);
            rd_addr2      = ($urandom_range(0, 3) == 0) ? rd_addr1 : 4'($urandom);
            tick();
            nChecks++; if (wb_valid !== (mHas && mPending && mWrites)) $display("FAIL rnd_wb_valid cycle %0d got %b want %b", c, wb_valid, mHas && mPending && mWrites); else nPass++;
            if (mHas && mPending && mWrites) begin
                nChecks++; if (wb_rd !== mRd || wb_data !== mData) $display("FAIL rnd_wb cycle %0d got %h/%h want %h/%h", c, wb_rd, wb_data, mRd, mData); else nPass++;
            end
            nChecks++; if (rd_data1 !== mRead(rd_addr1)) $display("FAIL rnd_rd1 cycle %0d addr %h got %h want %h", c, rd_addr1, rd_data1, mRead(rd_addr1)); else nPass++;
            nChecks++; if (rd_data2 !== mRead(rd_addr2)) $display("FAIL rnd_rd2 cycle %0d addr %h got %h want %h", c, rd_addr2, rd_data2, mRead(rd_addr2)); else nPass++;
            nChecks++; if (retired_count !== mCount) $display("FAIL rnd_count cycle %0d got %h want %h", c, retired_count, mCount); else nPass++;
        end
    endtask

    initial begin
        idle();
        rd_addr1 = '0; rd_addr2 = '0;
        mCount = '0; mHas = 1'b0; mPending = 1'b0; mWrites = 1'b0; mRd = '0; mData = '0;
        for (int i = 0; i < 16; i++) mRegs[i] = '0;
        #1;
        test_reset();
        test_alu_wb();
        test_call_priority();
        test_stall();
        test_flush();
        test_bypass();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
